// File: rtl/pixel_stream_serializer_if.sv
// pixel_stream_serializer_if: bundles the frame-BRAM read side and the
// chunked transmit side of the pixel stream serializer.
//   master - the serializer (drives BRAM address and the output chunks)
//   slave  - the environment (BRAM data and packetizer stall)
interface pixel_stream_serializer_if #(
  parameter int PIXEL_W = 8,
  parameter int OUT_W   = 2,
  parameter int ADDR_W  = 24
);
  logic [PIXEL_W-1:0] pixel;
  logic               stall;
  logic [ADDR_W-1:0]  pixel_addr;
  logic               axiov;
  logic [OUT_W-1:0]   axiod;
  logic               frame_done;

  modport master (
    input  pixel, stall,
    output pixel_addr, axiov, axiod, frame_done
  );

  modport slave (
    output pixel, stall,
    input  pixel_addr, axiov, axiod, frame_done
  );
endinterface

// File: rtl/pixel_stream_serializer.sv
// pixel_stream_serializer: reads pixels from a frame BRAM with READ_LAT
// cycles of read latency and emits each pixel as PIXEL_W/OUT_W chunks of
// OUT_W bits, either LSB chunk first or MSB chunk first. The next pixel is
// prefetched so that consecutive pixels stream without gaps; a stall from
// the packetizer pauses the stream at the next pixel boundary and the
// stream later resumes at the next unsent pixel.
//
// Optional build macro PIXEL_SERIALIZER_STATS_EN adds the pixels_sent and
// frames_sent counter outputs.
module pixel_stream_serializer #(
  parameter int PIXEL_W      = 8,
  parameter int OUT_W        = 2,
  parameter int READ_LAT     = 2,      // 0 .. CHUNKS-1
  parameter int ADDR_W       = 24,
  parameter int FRAME_PIXELS = 76800,
  parameter int LSB_FIRST    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  pixel_stream_serializer_if.master bus
`ifdef PIXEL_SERIALIZER_STATS_EN
  ,
  output logic [31:0]              pixels_sent,
  output logic [15:0]              frames_sent
`endif
);

  localparam int CHUNKS    = PIXEL_W / OUT_W;
  localparam int PRIME_CYC = (READ_LAT > 1) ? READ_LAT : 1;
  // Chunk index during which the prefetched address must already be on the
  // BRAM so that its data arrives exactly in the last-chunk cycle.
  localparam int PF_IDX    = CHUNKS - 1 - READ_LAT;
  localparam int IDX_W     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CNT_W     = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(CHUNKS - 1);
  localparam logic [IDX_W-1:0]  IDX_PF_PREV  = IDX_W'((PF_IDX > 0) ? PF_IDX - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_PRE_LAST = IDX_W'((CHUNKS > 1) ? CHUNKS - 2 : 0);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(PRIME_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_prime_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [PIXEL_W-1:0] r_shift;      // chunks not yet placed on axiod
  logic [ADDR_W-1:0]  r_addr;
  logic               r_last_pix;   // pixel on the wire is FRAME_PIXELS-1
  logic               r_axiov;
  logic [OUT_W-1:0]   r_axiod;
  logic               r_frame_done;

  logic               w_at_last;
  logic               w_prime_done;
  logic               w_load;
  logic               w_addr_step;
  logic               w_enter_last;
  logic               w_cur_last;
  logic [ADDR_W-1:0]  w_next_addr;
  logic [OUT_W-1:0]   w_first_chunk;
  logic [OUT_W-1:0]   w_next_chunk;
  logic [PIXEL_W-1:0] w_load_rest;
  logic [PIXEL_W-1:0] w_shift_rest;

  // Boundary and load conditions.
  assign w_at_last    = (r_state == SHIFT) && (r_idx == IDX_LAST);
  assign w_prime_done = (r_state == PRIME) && (r_prime_cnt == CNT_LAST);
  assign w_load       = w_prime_done || (w_at_last && !bus.stall);

  // Address advance: one step per pixel, timed so the BRAM data lands in the
  // last-chunk cycle. With maximum latency the step coincides with the load.
  assign w_addr_step  = (PF_IDX > 0) ? ((r_state == SHIFT) && (r_idx == IDX_PF_PREV))
                                     : w_load;
  assign w_next_addr  = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;

  // The address register still names the current pixel on its step edge, so
  // that edge is where we learn whether this pixel closes the frame.
  assign w_enter_last = (CHUNKS > 1) ? ((r_state == SHIFT) && (r_idx == IDX_PRE_LAST))
                                     : w_load;
  assign w_cur_last   = w_addr_step ? (r_addr == ADDR_LAST) : r_last_pix;

  // Chunk selection: the shift register moves the next chunk to the end
  // that feeds axiod, so chunk order is fixed purely by shift direction.
  assign w_first_chunk = (LSB_FIRST != 0) ? bus.pixel[OUT_W-1:0]
                                          : bus.pixel[PIXEL_W-1 -: OUT_W];
  assign w_load_rest   = (LSB_FIRST != 0) ? (bus.pixel >> OUT_W) : (bus.pixel << OUT_W);
  assign w_next_chunk  = (LSB_FIRST != 0) ? r_shift[OUT_W-1:0]
                                          : r_shift[PIXEL_W-1 -: OUT_W];
  assign w_shift_rest  = (LSB_FIRST != 0) ? (r_shift >> OUT_W) : (r_shift << OUT_W);

  // Control FSM with registered outputs: IDLE -> PRIME -> SHIFT, back to
  // IDLE only when a stall is seen in the last-chunk cycle.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prime_cnt  <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_last_pix   <= 1'b0;
      r_axiov      <= 1'b0;
      r_axiod      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_enter_last && w_cur_last;

      if (w_addr_step) begin
        r_addr     <= w_next_addr;
        r_last_pix <= (r_addr == ADDR_LAST);
      end

      if (w_load) begin
        r_state <= SHIFT;
        r_idx   <= '0;
        r_shift <= w_load_rest;
        r_axiod <= w_first_chunk;
        r_axiov <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_axiov <= 1'b0;
            r_axiod <= '0;
            if (!bus.stall) begin
              r_state     <= PRIME;
              r_prime_cnt <= '0;
            end
          end
          PRIME: begin
            r_prime_cnt <= r_prime_cnt + 1'b1;
          end
          SHIFT: begin
            if (w_at_last) begin
              // Only reached with stall=1: finish this pixel, then pause.
              r_state <= IDLE;
              r_idx   <= '0;
              r_axiov <= 1'b0;
              r_axiod <= '0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_axiod <= w_next_chunk;
              r_shift <= w_shift_rest;
            end
          end
          default: begin
            r_state <= IDLE;
            r_axiov <= 1'b0;
            r_axiod <= '0;
          end
        endcase
      end
    end
  end

  assign bus.pixel_addr = r_addr;
  assign bus.axiov      = r_axiov;
  assign bus.axiod      = r_axiod;
  assign bus.frame_done = r_frame_done;

`ifdef PIXEL_SERIALIZER_STATS_EN
  logic [31:0] r_pixels_sent;
  logic [15:0] r_frames_sent;

  // Completed-pixel and completed-frame counters; both wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixels_sent <= '0;
      r_frames_sent <= '0;
    end else begin
      if (w_at_last) begin
        r_pixels_sent <= r_pixels_sent + 32'd1;
      end
      if (r_frame_done) begin
        r_frames_sent <= r_frames_sent + 16'd1;
      end
    end
  end

  assign pixels_sent = r_pixels_sent;
  assign frames_sent = r_frames_sent;
`endif

endmodule

// File: tb/tb_pixel_stream_serializer.sv
// tb_pixel_stream_serializer: runs four differently parameterised
// serializers side by side against a BRAM model filled with random pixels.
// Each instance is compared every cycle with a stream-level reference:
// the frame is a list of pixels, each pixel a list of chunks, emitted in
// order with wrap at the frame end, paused only at pixel boundaries.
`timescale 1ns/1ps
module tb_pixel_stream_serializer;

  localparam int N_CFG  = 4;
  localparam int ADDR_W = 24;

  localparam int CFG_PW  [N_CFG] = '{8, 8, 12, 8};
  localparam int CFG_OW  [N_CFG] = '{2, 2, 4,  4};
  localparam int CFG_RL  [N_CFG] = '{2, 3, 1,  0};
  localparam int CFG_FP  [N_CFG] = '{6, 5, 4,  7};
  localparam int CFG_LSB [N_CFG] = '{1, 0, 1,  0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   stall_pct = 0;
  bit   end_checks = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N_CFG; g++) begin : g_cfg
    localparam int PW  = CFG_PW[g];
    localparam int OW  = CFG_OW[g];
    localparam int RL  = CFG_RL[g];
    localparam int FP  = CFG_FP[g];
    localparam int LSB = CFG_LSB[g];
    localparam int CH  = PW / OW;
    localparam int P   = (RL > 1) ? RL : 1;
    localparam int PF  = CH - 1 - RL;

    pixel_stream_serializer_if #(.PIXEL_W(PW), .OUT_W(OW), .ADDR_W(ADDR_W)) bus ();

`ifdef PIXEL_SERIALIZER_STATS_EN
    logic [31:0] pixels_sent;
    logic [15:0] frames_sent;
`endif

    pixel_stream_serializer #(
      .PIXEL_W     (PW),
      .OUT_W       (OW),
      .READ_LAT    (RL),
      .ADDR_W      (ADDR_W),
      .FRAME_PIXELS(FP),
      .LSB_FIRST   (LSB)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef PIXEL_SERIALIZER_STATS_EN
      ,
      .pixels_sent(pixels_sent),
      .frames_sent(frames_sent)
`endif
    );

    // Frame BRAM: data for an address appears RL cycles after it is presented.
    logic [PW-1:0]     mem [FP];
    logic [ADDR_W-1:0] rd_q [1:3];
    logic [ADDR_W-1:0] rd_addr;

    initial begin
      for (int i = 0; i < FP; i++) mem[i] = PW'($urandom);
    end

    always @(posedge clk) begin
      rd_q[1] <= bus.pixel_addr;
      rd_q[2] <= rd_q[1];
      rd_q[3] <= rd_q[2];
    end

    assign rd_addr   = (RL == 0) ? bus.pixel_addr : rd_q[(RL == 0) ? 1 : RL];
    assign bus.pixel = mem[32'(rd_addr) % FP];

    // Chunk c of pixel pix in transmit order.
    function automatic logic [31:0] chunk_of(input int pix, input int c);
      int          pos;
      logic [31:0] w;
      pos = (LSB != 0) ? c : CH - 1 - c;
      w   = 32'(mem[pix]);
      return (w >> (pos * OW)) & ((32'd1 << OW) - 32'd1);
    endfunction

    // Reference state: which pixel/chunk the wire carries this cycle, or how
    // many silent cycles remain before it resumes (-1: waiting for stall=0).
    bit m_valid;
    int m_pix, m_chunk, m_gap, m_pixels, m_frames, m_resumes;
    bit s;

    initial begin
      bus.stall = 1'b1;
      m_valid = 1'b0; m_pix = 0; m_chunk = 0; m_gap = -1;
      m_pixels = 0; m_frames = 0; m_resumes = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          check($sformatf("c%0d reset axiov", g), 32'(bus.axiov), 32'd0);
          check($sformatf("c%0d reset axiod", g), 32'(bus.axiod), 32'd0);
          check($sformatf("c%0d reset frame_done", g), 32'(bus.frame_done), 32'd0);
          check($sformatf("c%0d reset pixel_addr", g), 32'(bus.pixel_addr), 32'd0);
          m_valid = 1'b0; m_pix = 0; m_chunk = 0; m_gap = -1;
          m_pixels = 0; m_frames = 0;
        end else begin
          check($sformatf("c%0d axiov", g), 32'(bus.axiov), 32'(m_valid));
          if (m_valid) begin
            check($sformatf("c%0d axiod p%0d k%0d", g, m_pix, m_chunk),
                  32'(bus.axiod), chunk_of(m_pix, m_chunk));
            check($sformatf("c%0d frame_done", g), 32'(bus.frame_done),
                  32'((m_pix == FP - 1) && (m_chunk == CH - 1)));
            check($sformatf("c%0d pixel_addr stream", g), 32'(bus.pixel_addr),
                  32'((m_chunk >= PF) ? (m_pix + 1) % FP : m_pix));
          end else begin
            check($sformatf("c%0d idle axiod", g), 32'(bus.axiod), 32'd0);
            check($sformatf("c%0d idle frame_done", g), 32'(bus.frame_done), 32'd0);
            check($sformatf("c%0d idle pixel_addr", g), 32'(bus.pixel_addr), 32'(m_pix));
          end

          s = ($urandom_range(99) < stall_pct);
          bus.stall = s;

          if (m_valid) begin
            if (m_chunk == CH - 1) begin
              m_pixels++;
              if (m_pix == FP - 1) m_frames++;
              m_pix   = (m_pix + 1) % FP;
              m_chunk = 0;
              if (s) begin
                m_valid = 1'b0;
                m_gap   = -1;
              end
            end else begin
              m_chunk++;
            end
          end else if (m_gap < 0) begin
            if (!s) begin
              m_gap = P;
              m_resumes++;
            end
          end else begin
            m_gap--;
            if (m_gap == 0) m_valid = 1'b1;
          end
        end
      end
    end

    // Reset must clear the outputs without waiting for a clock edge.
    initial begin
      forever begin
        @(posedge rst);
        #1;
        check($sformatf("c%0d async reset axiov", g), 32'(bus.axiov), 32'd0);
        check($sformatf("c%0d async reset axiod", g), 32'(bus.axiod), 32'd0);
        check($sformatf("c%0d async reset pixel_addr", g), 32'(bus.pixel_addr), 32'd0);
`ifdef PIXEL_SERIALIZER_STATS_EN
        check($sformatf("c%0d async reset pixels_sent", g), pixels_sent, 32'd0);
`endif
      end
    end

    initial begin
      wait (end_checks);
      check($sformatf("c%0d frames completed", g), 32'(m_frames > 0), 32'd1);
      check($sformatf("c%0d stall resumes", g), 32'(m_resumes > 2), 32'd1);
`ifdef PIXEL_SERIALIZER_STATS_EN
      check($sformatf("c%0d pixels_sent", g), pixels_sent, 32'(m_pixels));
      check($sformatf("c%0d frames_sent", g), 32'(frames_sent), 32'(m_frames % 65536));
`endif
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    stall_pct = 0;                       // uninterrupted stream, frame wraps
    repeat (200) @(posedge clk);
    stall_pct = 30;                      // frequent pauses and stall pulses
    repeat (1500) @(posedge clk);
    stall_pct = 80;                      // mostly stalled, short bursts
    repeat (1000) @(posedge clk);

    stall_pct = 0;                       // reset in the middle of streaming
    repeat (37) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    stall_pct = 20;
    repeat (1500) @(posedge clk);

    @(posedge clk);
    #1 end_checks = 1'b1;
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
